mac_act_packer: RTL and testbench
=================================

// Module: mac_act_packer
// PURPOSE
//  Upstream feeder for the sequential QR accelerator MAC stage.
//  - Accepts activations as narrow beats of wordElements elements each.
//  - Packs each vector of inputElements activations into a full-width MAC vector.
//  - Presents the vector on a valid/ready port that drives the MAC stage's mac_data_i/mac_valid_i/ready_o.
//  - Double-buffered: the next vector fills while the current one waits for the MAC stage.
// PARAMETERS
//  inputBits      5    bits per activation (ternary trits + sign), passed through unmodified
//  inputElements  128  activations per MAC vector (= SRAM rows)
//  wordElements   8    activations per input beat; must divide inputElements
//  cntBits        16   width of the popped-vector counter
// PORTS
//  clk           in   1                         clock; all logic on posedge
//  rst           in   1                         synchronous, active-high reset
//  act_data_i    in   wordElements*inputBits    beat; element j at bits [j*inputBits +: inputBits]
//  act_valid_i   in   1                         beat valid
//  act_last_i    in   1                         last beat of vector (used only with ACT_PACK_ZEROPAD_EN)
//  act_ready_o   out  1                         beat accepted when act_valid_i & act_ready_o
//  mac_data_o    out  inputElements*inputBits   packed vector; element e at [e*inputBits +: inputBits]
//  mac_valid_o   out  1                         vector available
//  mac_ready_i   in   1                         MAC stage takes vector when mac_valid_o & mac_ready_i
//  beat_idx_o    out  $clog2(inputElements/wordElements)  next beat slot in the fill bank
//  vec_count_o   out  cntBits                   vectors popped since reset; wraps to 0
// BEHAVIOUR
//  - Reset (synchronous): both banks EMPTY; wr_ptr=rd_ptr=0; beat_idx_o=0; vec_count_o=0.
//    act_ready_o=0 during the rst cycle, 1 on the first cycle after. mac_valid_o=0.
//    mac_data_o=0 (bank storage cleared).
//  - Per-bank state: EMPTY -> FILLING (first beat accepted) -> FULL (last beat accepted) -> EMPTY (popped).
//  - Beat k of a vector writes elements k*wordElements .. k*wordElements+wordElements-1 of the wr_ptr bank.
//  - The final beat (k = inputElements/wordElements-1) marks the bank FULL, toggles wr_ptr, clears beat_idx.
//  - act_ready_o = !(bank[wr_ptr]==FULL); the beat index wraps only on a completed vector.
//  - mac_valid_o = (bank[rd_ptr]==FULL), registered.
//    Latency: last beat accepted in cycle N -> mac_valid_o=1 in N+1 when the read side was idle.
//  - mac_data_o reflects bank[rd_ptr] and is stable while mac_valid_o=1 and not yet popped.
//  - Pop: the bank goes EMPTY, rd_ptr toggles, vec_count_o increments (mod 2^cntBits).
//  - Simultaneous pop and last-beat fill on different banks in one cycle are both honoured.
//    With both banks FULL, a pop re-raises act_ready_o the next cycle.
//  - Throughput: one beat per cycle sustained when mac_ready_i stays high. No bubble between vectors.
//  - Reset mid-vector discards partial and full banks; no vector is emitted for discarded data.
//  - act_last_i is ignored when the macro below is undefined.
// CONFIGURATION
//  ACT_PACK_ZEROPAD_EN defined:
//    - act_last_i on beat k < final terminates the vector early.
//    - Elements from (k+1)*wordElements to the end are written 0; the bank goes FULL in the same cycle.
//    - act_last_i on the final beat behaves as normal completion.
//  ACT_PACK_ZEROPAD_EN undefined: act_last_i unused; every vector needs exactly inputElements/wordElements beats.
// TESTING
//  1. Feed 16 beats (defaults), element e = e%5-2, mac_ready_i=1.
//     -> one vector; mac_data_o[e]=e%5-2; mac_valid_o 1 cycle after beat 16; vec_count_o=1.
//  2. mac_ready_i=0 while streaming 48 beats.
//     -> act_ready_o drops after beat 32; mac_data_o holds vector 0.
//     Raise mac_ready_i -> vectors 0,1,2 in order; vec_count_o=3.
//  3. Continuous valid on both sides for 10 vectors.
//     -> act_ready_o never deasserts after the first vector; 160 beats in 160 cycles.
//  4. Assert rst after beat 7 of vector 1 while vector 0 is held.
//     -> next cycle mac_valid_o=0, beat_idx_o=0, vec_count_o=0; the next 16 beats form a clean vector.
//  5. Pop vector 0 in the same cycle as the last beat of vector 1 is accepted.
//     -> mac_valid_o stays 1 next cycle with vector 1 data; vec_count_o=1.
//  6. (ACT_PACK_ZEROPAD_EN) act_last_i on beat 3.
//     -> elements 0..31 from input, 32..127 = 0; mac_valid_o next cycle.
//     (Undefined) the same stimulus waits for 16 beats.

Source files
------------

// File: rtl/mac_act_packer.sv
// -----------------------------------------------------------------------------
// mac_act_packer
//   Upstream feeder for the sequential QR accelerator MAC stage. Activations
//   arrive as narrow beats of wordElements elements. They are packed into a
//   full vector of inputElements elements and presented to the MAC stage over
//   a valid/ready port. Two banks are used so that the next vector can fill
//   while the current one waits for the MAC stage.
//
//   Optional feature macro: ACT_PACK_ZEROPAD_EN
//     defined   : act_last_i on a beat before the final one closes the vector
//                 early; every element after that beat is written as zero.
//     undefined : act_last_i is ignored; each vector needs exactly
//                 inputElements/wordElements beats.
//
// Ports
//   clk          in   clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   act_data_i   in   input beat, element j at [j*inputBits +: inputBits]
//   act_valid_i  in   beat valid
//   act_last_i   in   last beat of the vector (zero-pad build only)
//   act_ready_o  out  beat accepted when act_valid_i & act_ready_o
//   mac_data_o   out  packed vector, element e at [e*inputBits +: inputBits]
//   mac_valid_o  out  vector available to the MAC stage
//   mac_ready_i  in   MAC stage takes the vector when mac_valid_o & mac_ready_i
//   beat_idx_o   out  next beat slot in the bank being filled
//   vec_count_o  out  vectors popped since reset, wraps to zero
// -----------------------------------------------------------------------------
module mac_act_packer #(
  parameter int inputBits     = 5,
  parameter int inputElements = 128,
  parameter int wordElements  = 8,
  parameter int cntBits       = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [wordElements*inputBits-1:0]            act_data_i,
  input  logic                                         act_valid_i,
  input  logic                                         act_last_i,
  output logic                                         act_ready_o,
  output logic [inputElements*inputBits-1:0]           mac_data_o,
  output logic                                         mac_valid_o,
  input  logic                                         mac_ready_i,
  output logic [$clog2(inputElements/wordElements)-1:0] beat_idx_o,
  output logic [cntBits-1:0]                           vec_count_o
);

  localparam int NBEATS = inputElements / wordElements;
  localparam int BEAT_W = wordElements * inputBits;
  localparam int IDX_W  = $clog2(NBEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  if ((inputElements % wordElements) != 0) begin : g_bad_cfg
    $error("mac_act_packer: wordElements must divide inputElements");
  end

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Control state
  bank_state_t             r_state [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [IDX_W-1:0]        r_beat_idx;
  logic [cntBits-1:0]      r_vec_count;

  // Bank storage, one beat-wide slot per beat position
  logic [NBEATS-1:0][BEAT_W-1:0] r_bank [2];

  bank_state_t             w_state_nxt [2];
  logic                    w_wr_ptr_nxt;
  logic                    w_rd_ptr_nxt;
  logic [IDX_W-1:0]        w_beat_idx_nxt;
  logic [cntBits-1:0]      w_vec_count_nxt;

  logic                    w_accept;
  logic                    w_pop;
  logic                    w_early_last;
  logic                    w_vec_end;

`ifdef ACT_PACK_ZEROPAD_EN
  assign w_early_last = act_last_i;
`else
  logic w_unused_last;
  assign w_unused_last = act_last_i;
  assign w_early_last  = 1'b0;
`endif

  // Ready only depends on whether the fill bank is still occupied by a full
  // vector; it is held low while reset is asserted.
  assign act_ready_o = !rst && (r_state[r_wr_ptr] != BANK_FULL);
  assign mac_valid_o = (r_state[r_rd_ptr] == BANK_FULL);
  assign mac_data_o  = r_bank[r_rd_ptr];
  assign beat_idx_o  = r_beat_idx;
  assign vec_count_o = r_vec_count;

  assign w_accept  = act_valid_i && act_ready_o;
  assign w_pop     = mac_valid_o && mac_ready_i;
  assign w_vec_end = (r_beat_idx == LAST_IDX) || w_early_last;

  // Fill and pop always target different banks: the fill bank is never FULL
  // when a beat is accepted, the read bank is always FULL when popped.
  always_comb begin
    w_state_nxt[0]  = r_state[0];
    w_state_nxt[1]  = r_state[1];
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_beat_idx_nxt  = r_beat_idx;
    w_vec_count_nxt = r_vec_count;

    if (w_accept) begin
      if (w_vec_end) begin
        w_state_nxt[r_wr_ptr] = BANK_FULL;
        w_wr_ptr_nxt          = ~r_wr_ptr;
        w_beat_idx_nxt        = '0;
      end else begin
        w_state_nxt[r_wr_ptr] = BANK_FILLING;
        w_beat_idx_nxt        = r_beat_idx + IDX_W'(1);
      end
    end

    if (w_pop) begin
      w_state_nxt[r_rd_ptr] = BANK_EMPTY;
      w_rd_ptr_nxt          = ~r_rd_ptr;
      w_vec_count_nxt       = r_vec_count + cntBits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state[0]  <= BANK_EMPTY;
      r_state[1]  <= BANK_EMPTY;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_beat_idx  <= '0;
      r_vec_count <= '0;
    end else begin
      r_state[0]  <= w_state_nxt[0];
      r_state[1]  <= w_state_nxt[1];
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_beat_idx  <= w_beat_idx_nxt;
      r_vec_count <= w_vec_count_nxt;
    end
  end

  // Bank writes. An early-terminated vector zeroes every slot after the
  // current beat so stale data from an older vector never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else if (w_accept) begin
      for (int s = 0; s < NBEATS; s++) begin
        if (IDX_W'(s) == r_beat_idx) begin
          r_bank[r_wr_ptr][s] <= act_data_i;
        end else if (w_early_last && (IDX_W'(s) > r_beat_idx)) begin
          r_bank[r_wr_ptr][s] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_act_packer.sv
module tb_mac_act_packer;

  localparam int IB = 5;
  localparam int IE = 128;
  localparam int WE = 8;
  localparam int CB = 16;
  localparam int NB = IE / WE;
  localparam int BW = WE * IB;
  localparam int VW = IE * IB;
  localparam int IW = $clog2(NB);
`ifdef ACT_PACK_ZEROPAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] act_data = '0;
  logic          act_valid = 1'b0;
  logic          act_last = 1'b0;
  logic          act_ready;
  logic [VW-1:0] mac_data;
  logic          mac_valid;
  logic          mac_ready = 1'b0;
  logic [IW-1:0] beat_idx;
  logic [CB-1:0] vec_count;

  always #5 clk = ~clk;

  mac_act_packer #(
    .inputBits(IB), .inputElements(IE), .wordElements(WE), .cntBits(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .act_data_i(act_data), .act_valid_i(act_valid), .act_last_i(act_last),
    .act_ready_o(act_ready),
    .mac_data_o(mac_data), .mac_valid_o(mac_valid), .mac_ready_i(mac_ready),
    .beat_idx_o(beat_idx), .vec_count_o(vec_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of complete vectors (at most two held), the
  // vector being assembled, and the pop counter.
  logic [VW-1:0] mq[$];
  logic [VW-1:0] m_part = '0;
  int            m_beat = 0;
  logic [CB-1:0] m_cnt = '0;

  int drv_vec = 0;
  int drv_beat = 0;
  bit rand_data = 1'b0;
  int dut_acc = 0;

  typedef struct {
    int rep; int v; int mr;
    int e_ardy; int e_mvld; int e_vec; int e_idx0; int e_inc; int e_cnt;
  } seg_t;
  seg_t tbl[11];

  function automatic logic [IB-1:0] elem(int v, int e);
    int x;
    x = ((e + v) % 5) - 2;
    return x[IB-1:0];
  endfunction

  function automatic logic [BW-1:0] beat_pat(int v, int k);
    logic [BW-1:0] r;
    for (int j = 0; j < WE; j++) r[j*IB +: IB] = elem(v, k*WE + j);
    return r;
  endfunction

  function automatic logic [VW-1:0] vec_pat(int v, int nb);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < nb; k++) r[k*BW +: BW] = beat_pat(v, k);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit l, input bit mr, input bit r);
    logic [63:0] t;
    rst = r;
    act_valid = v;
    act_last = l;
    mac_ready = mr;
    if (rand_data) begin
      t = {$urandom(), $urandom()};
      act_data = t[BW-1:0];
    end else begin
      act_data = beat_pat(drv_vec, drv_beat);
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    if (act_valid && act_ready === 1'b1) dut_acc++;
    chk("act_ready", 64'(act_ready), 64'(!rst && mq.size() < 2));
    chk("mac_valid", 64'(mac_valid), 64'(mq.size() > 0));
    chk("beat_idx", 64'(beat_idx), 64'(m_beat));
    chk("vec_count", 64'(vec_count), 64'(m_cnt));
    if (mq.size() > 0) chkv("mac_data", mac_data, mq[0]);
  endtask

  task automatic tick_b();
    bit acc;
    bit pop;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_part = '0;
      m_beat = 0;
      m_cnt = '0;
      drv_vec++;
      drv_beat = 0;
    end else begin
      acc = act_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && mac_ready;
      if (pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + CB'(1);
      end
      if (acc) begin
        m_part[m_beat*BW +: BW] = act_data;
        if (m_beat == NB - 1 || (ZP && act_last)) begin
          mq.push_back(m_part);
          m_part = '0;
          m_beat = 0;
          drv_vec++;
          drv_beat = 0;
        end else begin
          m_beat++;
          drv_beat++;
        end
      end
    end
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  initial begin
    int vid;
    int vid2;
    int a0;
    int c0;

    // Hold reset for two cycles
    drive(0, 0, 0, 1);
    repeat (2) tick_b();
    drv_vec = 0;
    drv_beat = 0;

    // Reset state
    drive(0, 0, 0, 0);
    tick_a();
    chk("rst_ready", 64'(act_ready), 64'(1));
    chk("rst_valid", 64'(mac_valid), 64'(0));
    chk("rst_idx", 64'(beat_idx), 64'(0));
    chk("rst_cnt", 64'(vec_count), 64'(0));
    chkv("rst_data", mac_data, '0);
    tick_b();

    // Directed single vector, then backpressure with 48 beats
    tbl[0]  = '{16, 1, 1, 1, 0, 0, 0, 1, 0};
    tbl[1]  = '{ 1, 0, 1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{ 1, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[3]  = '{16, 1, 0, 1, 0, 0, 0, 1, 1};
    tbl[4]  = '{16, 1, 0, 1, 1, 1, 0, 1, 1};
    tbl[5]  = '{ 3, 1, 0, 0, 1, 1, 0, 0, 1};
    tbl[6]  = '{ 1, 1, 1, 0, 1, 1, 0, 0, 1};
    tbl[7]  = '{16, 1, 0, 1, 1, 2, 0, 1, 2};
    tbl[8]  = '{ 1, 0, 1, 0, 1, 2, 0, 0, 2};
    tbl[9]  = '{ 1, 0, 1, 1, 1, 3, 0, 0, 3};
    tbl[10] = '{ 1, 0, 0, 1, 0, 0, 0, 0, 4};
    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        drive(tbl[i].v != 0, 0, tbl[i].mr != 0, 0);
        tick_a();
        chk($sformatf("tbl%0d_ardy", i), 64'(act_ready), 64'(tbl[i].e_ardy));
        chk($sformatf("tbl%0d_mvld", i), 64'(mac_valid), 64'(tbl[i].e_mvld));
        chk($sformatf("tbl%0d_idx", i), 64'(beat_idx),
            64'(tbl[i].e_idx0 + ((tbl[i].e_inc != 0) ? r : 0)));
        chk($sformatf("tbl%0d_cnt", i), 64'(vec_count), 64'(tbl[i].e_cnt));
        if (tbl[i].e_mvld != 0)
          chkv($sformatf("tbl%0d_data", i), mac_data, vec_pat(tbl[i].e_vec, NB));
        tick_b();
      end
    end

    // Sustained streaming: 10 vectors, 160 beats in 160 cycles
    a0 = dut_acc;
    c0 = int'(m_cnt);
    for (int i = 0; i < 160; i++) begin
      drive(1, 0, 1, 0);
      tick_a();
      chk("t3_ready", 64'(act_ready), 64'(1));
      tick_b();
    end
    chk("t3_beats", 64'(dut_acc - a0), 64'(160));
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    tick_a();
    chk("t3_count", 64'(vec_count), 64'(CB'(c0 + 10)));
    tick_b();

    // Reset mid-vector while a full vector is held
    for (int i = 0; i < 23; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 1);
    tick_a();
    chk("t4_rst_ready", 64'(act_ready), 64'(0));
    tick_b();
    drive(0, 0, 0, 0);
    tick_a();
    chk("t4_valid", 64'(mac_valid), 64'(0));
    chk("t4_idx", 64'(beat_idx), 64'(0));
    chk("t4_cnt", 64'(vec_count), 64'(0));
    chkv("t4_data", mac_data, '0);
    tick_b();
    vid = drv_vec;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    tick_a();
    chk("t4_vec_valid", 64'(mac_valid), 64'(1));
    chkv("t4_vec_data", mac_data, vec_pat(vid, NB));
    tick_b();
    drive(0, 0, 0, 0);
    tick_a();
    chk("t4_vec_cnt", 64'(vec_count), 64'(1));
    tick_b();

    // Pop of vector 0 coincides with the last beat of vector 1
    c0 = int'(m_cnt);
    vid = drv_vec;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    vid2 = drv_vec;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 0);
    tick_a();
    chk("t5_v0_valid", 64'(mac_valid), 64'(1));
    chkv("t5_v0_data", mac_data, vec_pat(vid, NB));
    tick_b();
    drive(0, 0, 0, 0);
    tick_a();
    chk("t5_v1_valid", 64'(mac_valid), 64'(1));
    chkv("t5_v1_data", mac_data, vec_pat(vid2, NB));
    chk("t5_cnt", 64'(vec_count), 64'(CB'(c0 + 1)));
    chk("t5_ready", 64'(act_ready), 64'(1));
    tick_b();
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();

    // act_last on beat 3
    vid = drv_vec;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick_a();
`ifdef ACT_PACK_ZEROPAD_EN
    chk("t6_valid", 64'(mac_valid), 64'(1));
    chk("t6_idx", 64'(beat_idx), 64'(0));
    chkv("t6_data", mac_data, vec_pat(vid, 4));
    tick_b();
`else
    chk("t6_valid", 64'(mac_valid), 64'(0));
    chk("t6_idx", 64'(beat_idx), 64'(4));
    tick_b();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    tick_a();
    chk("t6_full_valid", 64'(mac_valid), 64'(1));
    chkv("t6_full_data", mac_data, vec_pat(vid, NB));
    tick_b();
`endif
    drive(0, 0, 1, 0);
    tick();

    // Randomized traffic against the model
    rand_data = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom() % 10) < 7, ($urandom() % 20) == 0,
            ($urandom() % 10) < 6, $urandom_range(0, 299) == 0);
      tick();
    end
    rand_data = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
